// File: rtl/std_arb_pkg.sv
// std_arb_pkg: shared FSM state type and rotating first-set-bit search for the functional-unit arbiter
package std_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
   localparam int max_req = 32;
   // Returns {found, index} of the first set bit at or above ptr, wrapping modulo n.
   function automatic logic [5:0] rr_first(input logic [max_req-1:0] req, input logic [4:0] ptr, input logic [5:0] n);
      logic [5:0] j;
      rr_first = '0;
      for (int k = max_req - 1; k >= 0; k--) begin
         j = {1'b0, ptr} + 6'(k);
         if (j >= n) j = j - n;
         if (6'(k) < n && req[j[4:0]]) rr_first = {1'b1, j[4:0]};
      end
   endfunction
endpackage

// File: rtl/std_fu_arbiter_if.sv
// std_fu_arbiter_if: requester and functional-unit signals of the shared-unit arbiter
interface std_fu_arbiter_if #(parameter int width = 32, parameter int n_req = 4);
   localparam int idx_w = $clog2(n_req);
   logic [n_req-1:0]       req_valid;
   logic [n_req*width-1:0] req_left;
   logic [n_req*width-1:0] req_right;
   logic [n_req-1:0]       req_ready;
   logic [n_req-1:0]       done;
   logic [width-1:0]       result;
   logic [idx_w-1:0]       grant_id;
   logic                   fu_valid;
   logic [width-1:0]       fu_left;
   logic [width-1:0]       fu_right;
   logic                   fu_ready;
   logic [width-1:0]       fu_out;
   modport master (
      output req_valid, req_left, req_right, fu_ready, fu_out,
      input  req_ready, done, result, grant_id, fu_valid, fu_left, fu_right
   );
   modport slave (
      input  req_valid, req_left, req_right, fu_ready, fu_out,
      output req_ready, done, result, grant_id, fu_valid, fu_left, fu_right
   );
endinterface

// File: rtl/std_rr_pick.sv
// std_rr_pick: combinational round-robin pick of the first requester at or after ptr
module std_rr_pick import std_arb_pkg::*; #(
   parameter int n_req = 4,
   parameter int idx_w = $clog2(n_req)
) (
   input  logic [n_req-1:0] req,
   input  logic [idx_w-1:0] ptr,
   output logic             any,
   output logic [idx_w-1:0] idx,
   output logic [n_req-1:0] gnt
);
   logic [5:0] r;
   assign r   = rr_first(max_req'(req), 5'(ptr), 6'(n_req));
   assign any = r[5];
   assign idx = idx_w'(r[4:0]);
   assign gnt = any ? n_req'(1) << idx : '0;
endmodule

// File: rtl/std_fu_arbiter.sv
// std_fu_arbiter: round-robin time-sharing of one std_* functional unit among n_req requesters
module std_fu_arbiter import std_arb_pkg::*; #(
   parameter int width = 32,
   parameter int n_req = 4,
   localparam int idx_w = $clog2(n_req)
) (
   input logic            clk,
   input logic            reset_n,
   std_fu_arbiter_if.slave bus
);
   arb_state_t state, state_nx;
   logic [idx_w-1:0] ptr, grant_id, idx;
   logic [width-1:0] op_l, op_r, result;
   logic [width-1:0] l_arr [n_req];
   logic [width-1:0] r_arr [n_req];
   logic [n_req-1:0] req_ready, done, gnt;
   logic             any;
   for (genvar g = 0; g < n_req; g++) begin : g_unpack
      assign l_arr[g] = bus.req_left[g*width +: width];
      assign r_arr[g] = bus.req_right[g*width +: width];
   end
   std_rr_pick #(.n_req(n_req), .idx_w(idx_w)) u_pick (
      .req(bus.req_valid),
      .ptr(ptr),
      .any(any),
      .idx(idx),
      .gnt(gnt)
   );
   always_comb begin
      state_nx = state == IDLE ? (any ? BUSY : IDLE)
               : state == BUSY ? (bus.fu_ready ? DONE : BUSY)
               : IDLE;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ptr       <= '0;
         grant_id  <= '0;
         op_l      <= '0;
         op_r      <= '0;
         result    <= '0;
         req_ready <= '0;
         done      <= '0;
      end else begin
         state     <= state_nx;
         req_ready <= '0;
         done      <= '0;
         if (state == IDLE && any) begin
            op_l      <= l_arr[idx];
            op_r      <= r_arr[idx];
            grant_id  <= idx;
            req_ready <= gnt;
         end
         if (state == BUSY && bus.fu_ready) result <= bus.fu_out;
         if (state == DONE) begin
            done <= n_req'(1) << grant_id;
            ptr  <= grant_id == idx_w'(n_req - 1) ? '0 : grant_id + 1'b1;
         end
      end
   end
   // fu_valid decodes the state register so it drops asynchronously with reset
   assign bus.fu_valid  = state == BUSY;
   assign bus.fu_left   = op_l;
   assign bus.fu_right  = op_r;
   assign bus.req_ready = req_ready;
   assign bus.done      = done;
   assign bus.result    = result;
   assign bus.grant_id  = grant_id;
endmodule

// File: tb/tb_std_fu_arbiter.sv
// tb_std_fu_arbiter: directed vector table plus hand-written multi-cycle sequences for std_fu_arbiter
module tb_std_fu_arbiter;
   localparam int W = 32;
   localparam int N = 4;

   typedef struct {
      logic [N-1:0] valid;
      logic [W-1:0] l;
      logic [W-1:0] r;
      int           gnt;
      logic [W-1:0] res;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic slow = 1'b0;
   int   busy_cnt = 0;
   int   cyc = 0;
   int   vecs = 0;
   int   errs = 0;

   std_fu_arbiter_if #(.width(W), .n_req(N)) bus ();
   std_fu_arbiter #(.width(W), .n_req(N)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Unit model: an adder answering at once, or a slow unit raising ready after 4 BUSY cycles.
   always @(posedge clk) busy_cnt <= bus.fu_valid ? busy_cnt + 1 : 0;
   assign bus.fu_ready = !slow || busy_cnt >= 4;
   assign bus.fu_out   = slow ? 32'hDEADBEEF : bus.fu_left + bus.fu_right;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_ops(input int g, input logic [W-1:0] l, input logic [W-1:0] r);
      for (int i = 0; i < N; i++) begin
         bus.req_left[i*W +: W]  = i == g ? l : 32'(32'h1000_0000 * (i + 1));
         bus.req_right[i*W +: W] = i == g ? r : 32'(32'h0100_0000 * (i + 1));
      end
   endtask

   task automatic wait_ready(output int t);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.req_ready == '0 && n < 20);
      t = cyc;
      if (bus.req_ready == '0) begin
         vecs++;
         errs++;
         $display("FAIL ready_timeout: no req_ready within %0d cycles", n);
      end
   endtask

   task automatic wait_done(output int t);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.done == '0 && n < 20);
      t = cyc;
      if (bus.done == '0) begin
         vecs++;
         errs++;
         $display("FAIL done_timeout: no done within %0d cycles", n);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int t0, t1;
      @(negedge clk);
      set_ops(v.gnt, v.l, v.r);
      bus.req_valid = v.valid;
      wait_ready(t0);
      bus.req_valid = '0;
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'(1 << v.gnt));
      chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'(v.gnt));
      wait_done(t1);
      chk({tag, "_done"}, 32'(bus.done), 32'(1 << v.gnt));
      chk({tag, "_result"}, bus.result, v.res);
      chk({tag, "_latency"}, 32'(t1 - t0), 32'd2);
   endtask

   vec_t tv [8];

   initial begin
      int g [5];
      int d [5];
      int ng, nd, multi, lows, seen, t0, t1;
      logic prev_done;
      tv[0] = '{4'b1111, 32'd10,         32'd1,   0, 32'd11};
      tv[1] = '{4'b0100, 32'd5,          32'd7,   2, 32'd12};
      tv[2] = '{4'b1111, 32'hFFFF_FFFF,  32'd2,   3, 32'd1};
      tv[3] = '{4'b0010, 32'd100,        32'd200, 1, 32'd300};
      tv[4] = '{4'b1011, 32'd7,          32'd8,   3, 32'd15};
      tv[5] = '{4'b1010, 32'd1,          32'd1,   1, 32'd2};
      tv[6] = '{4'b0001, 32'd0,          32'd0,   0, 32'd0};
      tv[7] = '{4'b1001, 32'd40,         32'd2,   3, 32'd42};

      bus.req_valid = '1;
      bus.req_left  = '0;
      bus.req_right = '0;
      set_ops(1, 32'h55, 32'h66);
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
      chk("rst_fu_valid", 32'(bus.fu_valid), 32'd0);
      chk("rst_fu_left", bus.fu_left, 32'd0);
      chk("rst_fu_right", bus.fu_right, 32'd0);
      bus.req_valid = '0;
      reset_n = 1'b1;

      for (int k = 0; k < 8; k++) run_vec(tv[k], $sformatf("vec%0d", k));

      // All requesters held: grants rotate 0,1,2,3,0 with done pulses 3 cycles apart.
      @(negedge clk);
      set_ops(0, 32'd1, 32'd2);
      bus.req_valid = '1;
      ng = 0;
      nd = 0;
      multi = 0;
      prev_done = 1'b0;
      for (int c = 0; c < 40 && nd < 5; c++) begin
         @(negedge clk);
         if (bus.req_ready != '0 && ng < 5) begin
            g[ng] = 32'(bus.grant_id);
            ng++;
            if (ng == 5) bus.req_valid = '0;
         end
         if (bus.done != '0) begin
            d[nd] = cyc;
            nd++;
            if (prev_done) multi++;
         end
         prev_done = bus.done != '0;
      end
      chk("fair_grants", 32'(ng), 32'd5);
      chk("fair_dones", 32'(nd), 32'd5);
      for (int i = 0; i < 5; i++) if (i < ng) chk($sformatf("fair_gnt%0d", i), 32'(g[i]), 32'(i % N));
      for (int i = 1; i < 5; i++) if (i < nd) chk($sformatf("fair_gap%0d", i), 32'(d[i] - d[i-1]), 32'd3);
      chk("fair_done_width", 32'(multi), 32'd0);

      // Slow unit: ready low for 4 BUSY cycles, done 6 cycles after accept.
      slow = 1'b1;
      @(negedge clk);
      set_ops(2, 32'd9, 32'd9);
      bus.req_valid = 4'b0100;
      wait_ready(t0);
      bus.req_valid = '0;
      chk("slow_grant_id", 32'(bus.grant_id), 32'd2);
      lows = 0;
      for (int c = 0; c < 5; c++) begin
         if (!bus.fu_valid) lows++;
         @(negedge clk);
      end
      chk("slow_fu_valid_busy", 32'(lows), 32'd0);
      chk("slow_fu_valid_done", 32'(bus.fu_valid), 32'd0);
      wait_done(t1);
      chk("slow_latency", 32'(t1 - t0), 32'd6);
      chk("slow_done", 32'(bus.done), 32'b0100);
      chk("slow_result", bus.result, 32'hDEADBEEF);

      // Reset during BUSY: fu_valid drops at once, no done, ptr back to 0.
      @(negedge clk);
      set_ops(0, 32'd3, 32'd4);
      bus.req_valid = 4'b0001;
      wait_ready(t0);
      bus.req_valid = '0;
      @(negedge clk);
      chk("mid_fu_valid_busy", 32'(bus.fu_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1 chk("mid_fu_valid_async", 32'(bus.fu_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      slow = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done != '0) seen++;
      end
      chk("mid_no_done", 32'(seen), 32'd0);
      run_vec('{4'b1111, 32'd20, 32'd22, 0, 32'd42}, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/std_fu_arbiter.md
# std_fu_arbiter

Round-robin arbiter that time-shares one `std_*` functional unit (for example `std_mul` or `std_div`) among `n_req` requesters. It drives the unit's `valid`/operand inputs, waits for its `ready`, and returns the registered result to the requester that won the grant. It sits between the requesters and one shared arithmetic primitive, so a design instantiates one unit instead of `n_req`.

## Interface
Parameters:
- `width`, 32, operand/result width.
- `n_req`, 4, number of requesters (≥2).
- `idx_w`, `$clog2(n_req)`, grant-index width (derived; not overridden).

Ports (all widths in bits):
- `clk`  in  1  clock, all state on rising edge. One clock domain.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  n_req  requester i wants an operation; held until accepted.
- `req_left`  in  n_req*width  operand left, requester i at bits [i*width +: width].
- `req_right`  in  n_req*width  operand right, same packing.
- `req_ready`  out  n_req  one-hot, 1-cycle pulse: requester i's operands accepted this cycle.
- `done`  out  n_req  one-hot, 1-cycle pulse: result for requester i valid on `result`.
- `result`  out  width  registered result; holds last value between operations.
- `grant_id`  out  idx_w  index of the requester currently being served.
- `fu_valid`  out  1  to the unit's `valid`.
- `fu_left`, `fu_right`  out  width  to the unit's `left`/`right`.
- `fu_ready`  in  1  from the unit's `ready`.
- `fu_out`  in  width  from the unit's `out`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: when any `req_valid`, choose the winner. Start at `ptr`, scan upward modulo `n_req`, and take the first set bit. Then:
  - latch that requester's operands into `op_l`/`op_r`;
  - set `grant_id`;
  - pulse `req_ready[winner]`;
  - go to BUSY.
  - With no `req_valid`, stay in IDLE.
- BUSY: drive `fu_valid`=1, `fu_left`=`op_l`, `fu_right`=`op_r`. In the first cycle with `fu_ready`=1, capture `fu_out` into `result` and go to DONE. Otherwise stay in BUSY; there is no timeout.
- DONE: pulse `done[grant_id]`. Set `ptr` = `grant_id`+1; the value wraps from `n_req`-1 to 0. Go to IDLE.
- `fu_valid`=0 in IDLE and DONE. `fu_left`/`fu_right` keep the latched operands in every state.
- Only one operation is in flight at a time. `req_valid` changes on other requesters, or on the granted one after its acceptance, do not affect the current operation.
- Arithmetic is pass-through: no width change, truncation or sign handling inside the arbiter.

## Timing
- Reset values (async on `reset_n`=0, held until release): state=IDLE, `ptr`=0, `grant_id`=0, `req_ready`=0, `done`=0, `result`=0, `fu_valid`=0, `fu_left`=0, `fu_right`=0.
- Reset mid-operation: the in-flight request is dropped without a `done`. `fu_valid` falls asynchronously with `reset_n`.
- With a combinational unit (`fu_ready` tied to 1): accept in cycle 0, capture in cycle 1, `done` in cycle 2. Next accept is no earlier than cycle 3.
- With a unit taking k cycles to raise `fu_ready`, latency from accept to `done` is k+2. If `fu_ready` is already high in the first BUSY cycle, k=0.
- `req_ready` and `done` are registered outputs, asserted for exactly one cycle.
- A requester that sees `done` and re-asserts `req_valid` has lowest priority in the next IDLE, because `ptr` has moved past it.
- If all requesters are valid, grants go 0,1,2,…,n_req-1,0 and so on.

## Structure
- Package `std_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t`.
  - A function for the rotating first-set-bit search.
- Sub-module `std_rr_pick`:
  - combinational;
  - inputs `req[n_req]` and `ptr[idx_w]`;
  - outputs `any`, `idx[idx_w]` and a one-hot `gnt`.
- The arbiter instantiates `std_rr_pick` once. The rest is the FSM and registers.

## Test plan
- Reset: `reset_n`=0 while `req_valid`=4'b1111 → all outputs 0 and no `req_ready`. After release, the first grant goes to requester 0.
- Single op with `std_add` attached: requester 2 sends left=5, right=7 → `req_ready`=4'b0100 in cycle 0, `done`=4'b0100 with `result`=12 in cycle 2.
- Fairness: `req_valid`=4'b1111 held, with a combinational unit → `grant_id` sequence 0,1,2,3,0. Each `done` is one cycle, 3 cycles apart.
- Slow unit: `fu_ready` held low for 4 BUSY cycles, `fu_out`=32'hDEADBEEF → `done` 6 cycles after accept. `fu_valid` stays high through BUSY; `result`=32'hDEADBEEF.
- Wrap and skip: after requester 3 is served, `req_valid`=4'b0010 → requester 1 is granted. The next grant then starts its scan at 2.
- Reset mid-BUSY: `reset_n` pulsed low during BUSY → `fu_valid` falls the same cycle and no `done` is issued. After release the FSM is in IDLE with `ptr`=0.
